uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor to the team's fixed 8-bit, odd-parity, single-byte UART transmitter core. Serialises words onto a single `tx` line. Configurable items:
- clock and baud rate
- data width
- parity mode
- stop-bit count
An internal FIFO lets software/upstream logic queue several words. Frames are sent back-to-back with no idle gap. Sits between the command/data path and the board-level UART pin.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
BAUD, 19_200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 5208 at defaults)
DATA_BITS, 8, word width; legal 5..9
PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, queue depth; power of 2, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
send_data  input  1  write request; word accepted on rising clk when send_data && tx_ready
data_tx  input  DATA_BITS  word to queue
tx_ready  output  1  FIFO not full
tx_busy  output  1  FIFO non-empty or frame in progress
fifo_count  output  $clog2(FIFO_DEPTH)+1  words queued, excluding the word being shifted
tx  output  1  serial line, idles high

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on `clk`/`rst_n`. While `rst_n` = 0:
  - tx = 1, tx_busy = 0, tx_ready = 1, fifo_count = 0
  - FIFO emptied, FSM in IDLE, all counters 0
  - Reset asserted mid-frame aborts the frame and forces tx = 1 immediately.
- All outputs are registered or derived from registers; no combinational path from inputs to outputs.
- Push:
  - On a rising edge with send_data = 1 and tx_ready = 1, data_tx is written and fifo_count increments.
  - send_data while tx_ready = 0 is ignored: the word is dropped and no state changes.
  - tx_ready depends only on fifo_count < FIFO_DEPTH. A pop in the same cycle does not make a full FIFO accept.
- Simultaneous push and pop when not full: fifo_count unchanged, and both operations take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If fifo_count != 0, pop into the shift register and go to START at the next edge.
  - START: tx = 0 for CLKS_PER_BIT clocks.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT clocks.
  - PARITY: entered only when PARITY_MODE != 0.
    - Odd mode: bit = ~^word, so the total count of ones is odd.
    - Even mode: bit = ^word.
    - Duration CLKS_PER_BIT.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT clocks.
    - At the final clock, if the FIFO is non-empty, pop and go directly to START; no extra idle cycles.
    - Otherwise go to IDLE.
- Latency:
  - Push at edge N into an empty FIFO with the FSM in IDLE gives fifo_count = 1 and tx_busy = 1 after edge N.
  - The pop and tx falling to the start bit happen after edge N+1.
- tx_busy = (fifo_count != 0) || (state != IDLE). It falls the cycle after the last stop bit completes with the FIFO empty.
- Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT clocks exactly.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit index advances only on wrap.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_count.
- data_tx changing after acceptance has no effect on queued or in-flight words.

Test Plan:
- Defaults, reset then push 0xA5 → after edge N+1, tx bit sequence per 5208 clocks is 0, 1,0,1,0,0,1,0,1, parity 1, stop 1. tx_busy is low 57,288 clocks after the start bit begins.
- PARITY_MODE = 2, push 0x07 → parity bit 1. With PARITY_MODE = 1 the same word gives parity bit 0. Also check 0x00 gives parity 0 (even) and 1 (odd).
- DATA_BITS = 7, PARITY_MODE = 0, STOP_BITS = 2, push 7'h55 → frame = start, 1010101, high for 2 bit times. Total 10*5208 clocks with no parity slot.
- send_data held high for 6 consecutive edges with bytes 0x11..0x66 from idle, FIFO_DEPTH = 4:
  - 0x11..0x55 are accepted and tx_ready = 0 after the 5th edge.
  - 0x66 is dropped and fifo_count = 4.
  - Output is five back-to-back frames with no idle clocks between a stop bit and the next start bit.
- Push 0x3C, assert rst_n = 0 mid-DATA for 3 clocks → tx = 1 asynchronously, fifo_count = 0, tx_busy = 0. After release, tx stays 1 and a new push of 0xC3 transmits correctly.
- Soak: 50 random words at random push intervals; the scoreboard decodes tx at mid-bit and matches data, parity and stop bits with zero mismatches.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word queue. Frames are start, DATA_BITS data (LSB first),
// optional parity and STOP_BITS stop bits, sent back-to-back while words remain queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD        = 19_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          send_data,
    input  logic [DATA_BITS-1:0]          data_tx,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_FW       = PTR_W + 1;
    localparam int IDX_W        = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   pop_word;
    logic                   par_bit;
    logic                   push, pop, tick, shift;

    // Handshake: a word is taken on a rising edge when send_data && tx_ready; tx_ready is
    // purely "not full", so a pop in the same cycle never lets a full queue accept.
    assign tx_ready = fifo_count < CNT_FW'(FIFO_DEPTH);
    assign push     = send_data && tx_ready;
    assign tick     = baud_cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign tx_busy  = (fifo_count != '0) || (state != IDLE);
    assign pop_word = mem[rd_ptr];

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift = 1'b1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_n = '0;
                        // Chain straight into the next start bit so frames have no idle gap.
                        if (fifo_count != '0) begin
                            pop     = 1'b1;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            PARITY:  tx = par_bit;
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_tx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            bit_idx <= bit_idx_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_FW'(1);
                2'b01:   fifo_count <= fifo_count - CNT_FW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (state == IDLE || tick) baud_cnt <= '0;
            else                       baud_cnt <= baud_cnt + 1'b1;
            if (pop) begin
                shreg   <= pop_word;
                par_bit <= (PARITY_MODE == 2) ? ^pop_word : ~^pop_word;
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
        end
    end
endmodule
